// File: rtl/sdrc_bank_arb_pkg.sv
// sdrc_bank_arb_pkg: command/state encodings, widths and helpers shared by the bank arbiter
package sdrc_bank_arb_pkg;
  localparam int SDR_REQ_ID_W = 4;
  localparam int REQ_BW = 3;
  typedef enum logic [1:0] {OP_PRE = 2'd0, OP_ACT = 2'd1, OP_RD = 2'd2, OP_WR = 2'd3} op_e;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_e;
  function automatic logic is_row(input logic [1:0] c);
    return c == OP_PRE || c == OP_ACT;
  endfunction
endpackage

// File: rtl/sdrc_bank_arb_rr_pick.sv
// sdrc_rr_pick: first set bit of mask_i at or after rr_i (mod NB); ports mask_i, rr_i -> valid_o, idx_o
module sdrc_rr_pick #(
  parameter int NB = 4
) (
  input  logic [NB-1:0] mask_i,
  input  logic [1:0]    rr_i,
  output logic          valid_o,
  output logic [1:0]    idx_o
);
  assign valid_o = |mask_i;
  always_comb begin
    idx_o = rr_i;
    for (int k = NB - 1; k >= 0; k--)
      if (mask_i[rr_i + 2'(k)]) idx_o = rr_i + 2'(k);
  end
endmodule

// File: rtl/sdrc_bank_arb.sv
// sdrc_bank_arb: grants one of NB bank requests (bk_*) to the transfer controller (x_*), routes x_ack back as bk_ack
module sdrc_bank_arb
  import sdrc_bank_arb_pkg::*;
#(
  parameter int NB     = 4,
  parameter int ID_W   = SDR_REQ_ID_W,
  parameter int LEN_W  = REQ_BW,
  parameter int STARVE = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NB-1:0]       bk_req,
  input  logic [2*NB-1:0]     bk_cmd,
  input  logic [13*NB-1:0]    bk_addr,
  input  logic [ID_W*NB-1:0]  bk_id,
  input  logic [LEN_W*NB-1:0] bk_len,
  input  logic [NB-1:0]       bk_start,
  input  logic [NB-1:0]       bk_last,
  input  logic [NB-1:0]       bk_wrap,
  output logic [NB-1:0]       bk_ack,
  output logic                x_req,
  output logic [1:0]          x_cmd,
  output logic [1:0]          x_ba,
  output logic [12:0]         x_addr,
  output logic [ID_W-1:0]     x_id,
  output logic [LEN_W-1:0]    x_len,
  output logic                x_start,
  output logic                x_last,
  output logic                x_wrap,
  input  logic                x_ack,
  input  logic [3:0]          trrd_delay
);
  localparam int SW = $clog2(STARVE + 1);
  arb_state_e state_q, state_d;
  logic [1:0] g_q, g_d, rr_q, rr_d;
  logic [3:0] trrd_q, trrd_d;
  logic [SW-1:0] starve_q [NB];
  logic [SW-1:0] starve_d [NB];
  logic [1:0] cmd [NB];
  logic [12:0] addr [NB];
  logic [ID_W-1:0] id [NB];
  logic [LEN_W-1:0] len [NB];
  logic [NB-1:0] elig, cls_a, cls_b;
  logic a_vld, b_vld, grant, acked;
  logic [1:0] a_idx, b_idx;
  for (genvar i = 0; i < NB; i++) begin : g_bank
    assign cmd[i]   = bk_cmd[2*i +: 2];
    assign addr[i]  = bk_addr[13*i +: 13];
    assign id[i]    = bk_id[ID_W*i +: ID_W];
    assign len[i]   = bk_len[LEN_W*i +: LEN_W];
    assign elig[i]  = bk_req[i] && !(cmd[i] == OP_ACT && trrd_q != 4'd0);
    assign cls_a[i] = elig[i] && (is_row(cmd[i]) || starve_q[i] == SW'(STARVE));
  end
  assign cls_b = elig & ~cls_a;
  sdrc_rr_pick #(.NB(NB)) u_pick_a (.mask_i(cls_a), .rr_i(rr_q), .valid_o(a_vld), .idx_o(a_idx));
  sdrc_rr_pick #(.NB(NB)) u_pick_b (.mask_i(cls_b), .rr_i(rr_q), .valid_o(b_vld), .idx_o(b_idx));
  assign grant   = state_q == ARB_GRANT;
  assign acked   = grant && x_ack;
  assign bk_ack  = acked ? NB'(1) << g_q : '0;
  assign x_req   = grant && bk_req[g_q];
  assign x_cmd   = grant ? cmd[g_q] : '0;
  assign x_ba    = grant ? g_q : '0;
  assign x_addr  = grant ? addr[g_q] : '0;
  assign x_id    = grant ? id[g_q] : '0;
  assign x_len   = grant ? len[g_q] : '0;
  assign x_start = grant && bk_start[g_q];
  assign x_last  = grant && bk_last[g_q];
  assign x_wrap  = grant && bk_wrap[g_q];
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    trrd_d  = (acked && cmd[g_q] == OP_ACT) ? trrd_delay : (trrd_q != 4'd0 ? trrd_q - 4'd1 : 4'd0);
    if (!grant) begin
      state_d = (a_vld || b_vld) ? ARB_GRANT : ARB_IDLE;
      g_d     = a_vld ? a_idx : (b_vld ? b_idx : g_q);
    end else if (x_ack) begin
      state_d = ARB_IDLE;
      rr_d    = g_q + 2'd1;
    end else if (!bk_req[g_q]) begin
      state_d = ARB_IDLE;
    end
    for (int i = 0; i < NB; i++)
      starve_d[i] = (bk_ack[i] || !bk_req[i]) ? '0 :
                    (!is_row(cmd[i]) && starve_q[i] != SW'(STARVE)) ? starve_q[i] + SW'(1) : starve_q[i];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      trrd_q  <= '0;
      for (int i = 0; i < NB; i++) starve_q[i] <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      trrd_q  <= trrd_d;
      for (int i = 0; i < NB; i++) starve_q[i] <= starve_d[i];
    end
  end
endmodule

// File: tb/tb_sdrc_bank_arb.sv
// tb_sdrc_bank_arb: directed self-checking bench for sdrc_bank_arb
module tb_sdrc_bank_arb;
  import sdrc_bank_arb_pkg::*;
  localparam int NB = 4;
  localparam int ID_W = SDR_REQ_ID_W;
  localparam int LEN_W = REQ_BW;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [NB-1:0] req = '0;
  logic [1:0] cmd [NB];
  logic [12:0] addr [NB];
  logic [ID_W-1:0] id [NB];
  logic [LEN_W-1:0] len [NB];
  logic [NB-1:0] st, la, wr;
  logic [2*NB-1:0] bk_cmd;
  logic [13*NB-1:0] bk_addr;
  logic [ID_W*NB-1:0] bk_id;
  logic [LEN_W*NB-1:0] bk_len;
  logic [NB-1:0] bk_ack;
  logic x_req, x_start, x_last, x_wrap;
  logic x_ack = 1'b0;
  logic [1:0] x_cmd, x_ba;
  logic [12:0] x_addr;
  logic [ID_W-1:0] x_id;
  logic [LEN_W-1:0] x_len;
  logic [3:0] trrd_delay = 4'd0;
  int errors = 0;
  int checks = 0;
  int seq [8];
  int gap [8];
  always_comb
    for (int i = 0; i < NB; i++) begin
      bk_cmd[2*i +: 2]         = cmd[i];
      bk_addr[13*i +: 13]      = addr[i];
      bk_id[ID_W*i +: ID_W]    = id[i];
      bk_len[LEN_W*i +: LEN_W] = len[i];
    end
  sdrc_bank_arb #(.NB(NB), .ID_W(ID_W), .LEN_W(LEN_W), .STARVE(8)) dut (
    .clk(clk), .reset_n(reset_n), .bk_req(req), .bk_cmd(bk_cmd), .bk_addr(bk_addr),
    .bk_id(bk_id), .bk_len(bk_len), .bk_start(st), .bk_last(la), .bk_wrap(wr),
    .bk_ack(bk_ack), .x_req(x_req), .x_cmd(x_cmd), .x_ba(x_ba), .x_addr(x_addr),
    .x_id(x_id), .x_len(x_len), .x_start(x_start), .x_last(x_last), .x_wrap(x_wrap),
    .x_ack(x_ack), .trrd_delay(trrd_delay)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    x_ack = 1'b0;
    for (int i = 0; i < NB; i++) cmd[i] = OP_RD;
    tick();
    tick();
    reset_n = 1'b1;
  endtask
  task automatic wait_grant(input string tag, output int ba, output int n);
    n = 0;
    while (!x_req && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_granted"}, 32'(x_req), 32'd1);
    ba = int'(x_ba);
  endtask
  task automatic ack_drop(input string tag);
    int b;
    b = int'(x_ba);
    x_ack = 1'b1;
    #1;
    chk({tag, "_bk_ack"}, 32'(bk_ack), 32'(4'b0001 << b));
    tick();
    x_ack = 1'b0;
    req[b] = 1'b0;
    #1;
    chk({tag, "_released"}, 32'(x_req), 32'd0);
  endtask
  task automatic run_grants(input int k);
    int n, last;
    n = 0;
    last = 0;
    for (int c = 0; c < 60 && n < k; c++) begin
      tick();
      if (x_req) begin
        seq[n] = int'(x_ba);
        gap[n] = c - last;
        last = c;
        n++;
        x_ack = 1'b1;
        #1;
        chk("rg_bk_ack", 32'(bk_ack), 32'(4'b0001 << x_ba));
      end else x_ack = 1'b0;
    end
    chk("rg_count", n, k);
    tick();
    x_ack = 1'b0;
  endtask
  initial begin
    int b, n;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int sv_exp [5] = '{0, 2, 3, 0, 1};
    for (int i = 0; i < NB; i++) begin
      cmd[i]  = OP_RD;
      addr[i] = 13'(256 * (i + 1) + i);
      id[i]   = ID_W'(i + 5);
      len[i]  = LEN_W'(i + 1);
      st[i]   = 1'(i % 2);
      la[i]   = 1'(i / 2);
      wr[i]   = 1'((i + 1) % 2);
    end
    do_reset();
    chk("rst_x_req", 32'(x_req), 0);
    chk("rst_bk_ack", 32'(bk_ack), 0);
    chk("rst_x_ba", 32'(x_ba), 0);
    chk("rst_x_cmd", 32'(x_cmd), 0);
    chk("rst_x_addr", 32'(x_addr), 0);
    chk("rst_x_id", 32'(x_id), 0);
    cmd[2] = OP_PRE;
    req[2] = 1'b1;
    #1;
    chk("pre_t0_x_req", 32'(x_req), 0);
    tick();
    chk("pre_t1_x_req", 32'(x_req), 1);
    chk("pre_t1_x_ba", 32'(x_ba), 2);
    chk("pre_t1_x_cmd", 32'(x_cmd), 32'(OP_PRE));
    chk("pre_t1_x_addr", 32'(x_addr), 32'h302);
    chk("pre_t1_x_id", 32'(x_id), 7);
    chk("pre_t1_x_len", 32'(x_len), 3);
    chk("pre_t1_flags", 32'({x_start, x_last, x_wrap}), 32'b011);
    tick();
    chk("pre_t2_bk_ack", 32'(bk_ack), 0);
    tick();
    ack_drop("pre");
    do_reset();
    req = 4'hF;
    run_grants(5);
    req = '0;
    for (int i = 0; i < 5; i++) chk("rr_order", seq[i], rr_exp[i]);
    for (int i = 1; i < 5; i++) chk("rr_gap", gap[i], 2);
    do_reset();
    cmd[3] = OP_ACT;
    req[0] = 1'b1;
    req[3] = 1'b1;
    wait_grant("prio1", b, n);
    chk("prio1_ba", b, 3);
    chk("prio1_cmd", 32'(x_cmd), 32'(OP_ACT));
    ack_drop("prio1");
    wait_grant("prio2", b, n);
    chk("prio2_ba", b, 0);
    chk("prio2_bubble", n, 1);
    ack_drop("prio2");
    do_reset();
    trrd_delay = 4'd3;
    cmd[0] = OP_ACT;
    cmd[1] = OP_ACT;
    req[1:0] = 2'b11;
    wait_grant("trrd1", b, n);
    chk("trrd1_ba", b, 0);
    ack_drop("trrd1");
    wait_grant("trrd2", b, n);
    chk("trrd2_ba", b, 1);
    chk("trrd2_wait", n, 4);
    ack_drop("trrd2");
    do_reset();
    trrd_delay = 4'd0;
    cmd[0] = OP_ACT;
    cmd[1] = OP_ACT;
    req[1:0] = 2'b11;
    wait_grant("trrd0a", b, n);
    ack_drop("trrd0a");
    wait_grant("trrd0b", b, n);
    chk("trrd0b_ba", b, 1);
    chk("trrd0b_wait", n, 1);
    ack_drop("trrd0b");
    do_reset();
    cmd[0] = OP_PRE;
    cmd[2] = OP_ACT;
    cmd[3] = OP_PRE;
    req = 4'hF;
    run_grants(5);
    req = '0;
    for (int i = 0; i < 5; i++) chk("starve_order", seq[i], sv_exp[i]);
    do_reset();
    x_ack = 1'b1;
    #1;
    chk("spur_bk_ack", 32'(bk_ack), 0);
    tick();
    chk("spur_x_req", 32'(x_req), 0);
    x_ack = 1'b0;
    req[2] = 1'b1;
    wait_grant("wd", b, n);
    chk("wd_ba", b, 2);
    req[2] = 1'b0;
    #1;
    chk("wd_x_req", 32'(x_req), 0);
    chk("wd_bk_ack", 32'(bk_ack), 0);
    tick();
    chk("wd_idle_x_req", 32'(x_req), 0);
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_grant("wd_rr", b, n);
    chk("wd_rr_ba", b, 1);
    reset_n = 1'b0;
    tick();
    chk("rst_mid_x_req", 32'(x_req), 0);
    chk("rst_mid_x_ba", 32'(x_ba), 0);
    chk("rst_mid_x_addr", 32'(x_addr), 0);
    chk("rst_mid_bk_ack", 32'(bk_ack), 0);
    reset_n = 1'b1;
    wait_grant("regrant", b, n);
    chk("regrant_ba", b, 1);
    req[1] = 1'b0;
    x_ack = 1'b1;
    #1;
    chk("sim_bk_ack", 32'(bk_ack), 32'b0010);
    tick();
    x_ack = 1'b0;
    wait_grant("sim_next", b, n);
    chk("sim_next_ba", b, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
